// File: rtl/bus_responder_pkg.sv
// Shared bus constants, FSM state encoding and address-region decode.
package bus_responder_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  // Data returned to the CPU when a peripheral read is never acknowledged.
  localparam logic [DATA_W-1:0] RD_TIMEOUT_DATA = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_REQ   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    REGION_RAM = 1'b0,
    REGION_PER = 1'b1
  } region_e;

  // Posted-write buffer entry.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  // RAM window is [base, base + words); widened so base + words may reach 2^16.
  function automatic region_e decode_region(input logic [ADDR_W-1:0] addr,
                                            input logic [ADDR_W-1:0] base,
                                            input int unsigned       words);
    logic [ADDR_W:0] off;
    off = {1'b0, addr} - {1'b0, base};
    if ((addr >= base) && (32'(off) < words)) return REGION_RAM;
    return REGION_PER;
  endfunction

endpackage

// File: rtl/post_fifo.sv
// Posted-write buffer: circular FIFO with registered full/empty flags.
module post_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic             do_push, do_pop;

  // Qualify requests against current occupancy and compute next count.
  always_comb begin
    do_push   = push && !full;
    do_pop    = pop && !empty;
    count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
    head_c    = mem[rd_ptr];
  end

  // Pointer, count and flag state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Entry storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bus_responder.sv
// CPU bus responder: local RAM window plus a posted-write/blocking-read
// peripheral channel with ack timeout.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter logic [15:0] RAM_BASE    = 16'h0000,
  parameter int unsigned RAM_WORDS   = 2048,
  parameter int unsigned WFIFO_DEPTH = 2,
  parameter logic [7:0]  TIMEOUT     = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        rw,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        ready,
  output logic        per_req,
  output logic        per_we,
  output logic [15:0] per_addr,
  output logic [7:0]  per_wdata,
  input  logic        per_ack,
  input  logic [7:0]  per_rdata,
  output logic        err_ovf,
  output logic        err_tmo
);

  localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  state_e            state, state_nxt;
  logic [7:0]        mem [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx_c;
  logic              req_c, is_ram_c, ram_rd_c, ram_wr_c, per_rd_c, per_wr_c;
  logic              push_c, pop_c, ack_c, tmo_hit_c, chan_done_c;
  logic              launch_rd_c, launch_wr_c;
  logic [15:0]       launch_addr_c, rd_addr_q;
  logic [7:0]        tmo_cnt;
  logic              fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_head_raw;
  wr_entry_t         fifo_head_c;

  assign fifo_head_c = wr_entry_t'(fifo_head_raw);

  post_fifo #(
    .DEPTH (WFIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_post_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push_c),
    .pop    (pop_c),
    .din    ({addr, wdata}),
    .head_c (fifo_head_raw),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Request-cycle decode and peripheral channel completion events.
  always_comb begin
    req_c       = ready && (state == ST_IDLE);
    is_ram_c    = (decode_region(addr, RAM_BASE, RAM_WORDS) == REGION_RAM);
    ram_rd_c    = req_c && is_ram_c && rw;
    ram_wr_c    = req_c && is_ram_c && !rw;
    per_rd_c    = req_c && !is_ram_c && rw;
    per_wr_c    = req_c && !is_ram_c && !rw;
    ram_idx_c   = RAM_AW'(addr - RAM_BASE);
    push_c      = per_wr_c && !fifo_full;
    ack_c       = per_req && per_ack;
    tmo_hit_c   = per_req && !per_ack && (tmo_cnt == TIMEOUT - 8'd1);
    chan_done_c = ack_c || tmo_hit_c;
    pop_c       = per_we && chan_done_c;
  end

  // Next state; an empty write buffer lets a read skip DRAIN and launch at once.
  always_comb begin
    state_nxt     = state;
    launch_rd_c   = 1'b0;
    launch_addr_c = rd_addr_q;
    case (state)
      ST_IDLE: begin
        if (per_rd_c) begin
          if (fifo_empty) begin
            state_nxt     = ST_REQ;
            launch_rd_c   = 1'b1;
            launch_addr_c = addr;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_nxt   = ST_REQ;
          launch_rd_c = 1'b1;
        end
      end
      ST_REQ:  if (chan_done_c) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    launch_wr_c = (state != ST_REQ) && !launch_rd_c && !fifo_empty && !per_req;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Peripheral channel: hold request until ack or timeout, then drop for a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_req   <= 1'b0;
      per_we    <= 1'b0;
      per_addr  <= '0;
      per_wdata <= '0;
      tmo_cnt   <= '0;
    end else begin
      if (launch_rd_c) begin
        per_req   <= 1'b1;
        per_we    <= 1'b0;
        per_addr  <= launch_addr_c;
        per_wdata <= 8'h00;
        tmo_cnt   <= '0;
      end else if (launch_wr_c) begin
        per_req   <= 1'b1;
        per_we    <= 1'b1;
        per_addr  <= fifo_head_c.addr;
        per_wdata <= fifo_head_c.data;
        tmo_cnt   <= '0;
      end else if (chan_done_c) begin
        per_req <= 1'b0;
        tmo_cnt <= '0;
      end else if (per_req) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

  // CPU-side return path: ready tracks IDLE/DONE, rdata from RAM or peripheral.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready     <= 1'b1;
      rdata     <= 8'h00;
      rd_addr_q <= '0;
    end else begin
      ready <= (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
      if ((state == ST_REQ) && chan_done_c) rdata <= ack_c ? per_rdata : RD_TIMEOUT_DATA;
      else if (ram_rd_c)                    rdata <= mem[ram_idx_c];
      if (per_rd_c) rd_addr_q <= addr;
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_tmo <= 1'b0;
    end else begin
      if (per_wr_c && fifo_full) err_ovf <= 1'b1;
      if (tmo_hit_c)             err_tmo <= 1'b1;
    end
  end

  // RAM array; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_wr_c) mem[ram_idx_c] <= wdata;
  end

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: directed scenarios plus a randomized
// mix checked against a transaction-level RAM/peripheral model.
`timescale 1ns/1ps
module tb_bus_responder;

  localparam logic [15:0] RAM_BASE    = 16'h0000;
  localparam int unsigned RAM_WORDS   = 2048;
  localparam int unsigned WFIFO_DEPTH = 2;
  localparam int          LIMIT       = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        rw;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ready;
  logic        per_req, per_we;
  logic [15:0] per_addr;
  logic [7:0]  per_wdata;
  logic        per_ack;
  logic [7:0]  per_rdata;
  logic        err_ovf, err_tmo;

  int n_cmp = 0;
  int n_bad = 0;

  // Peripheral model controls and observed-transaction log {we, addr, data}.
  bit          ack_en = 1'b1;
  int          lat_min = 0, lat_max = 0;
  bit          use_fixed = 1'b0;
  logic [7:0]  fixed_rdata = 8'h00;
  logic [24:0] log_q[$];
  logic [24:0] exp_wr[$];
  logic [7:0]  ram_model [RAM_WORDS];
  bit          err_ovf_exp = 1'b0, err_tmo_exp = 1'b0;

  bus_responder #(
    .RAM_BASE    (RAM_BASE),
    .RAM_WORDS   (RAM_WORDS),
    .WFIFO_DEPTH (WFIFO_DEPTH),
    .TIMEOUT     (8'd255)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .rw        (rw),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .per_req   (per_req),
    .per_we    (per_we),
    .per_addr  (per_addr),
    .per_wdata (per_wdata),
    .per_ack   (per_ack),
    .per_rdata (per_rdata),
    .err_ovf   (err_ovf),
    .err_tmo   (err_tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Peripheral: acks after a random number of cycles, checks request stability.
  initial begin
    int          wcnt;
    bit          active;
    logic [24:0] cap;
    per_ack   = 1'b0;
    per_rdata = 8'h00;
    wcnt      = 0;
    active    = 1'b0;
    cap       = '0;
    forever begin
      @(negedge clk);
      if (per_ack) begin
        per_ack = 1'b0;
        active  = 1'b0;
        wcnt    = int'($urandom_range(lat_max, lat_min));
      end else if (!per_req) begin
        active = 1'b0;
        wcnt   = int'($urandom_range(lat_max, lat_min));
      end else begin
        if (!active) begin
          active = 1'b1;
          cap    = {per_we, per_addr, per_wdata};
        end
        if (ack_en) begin
          if (wcnt == 0) begin
            check("hs_stable", 32'({per_we, per_addr, per_wdata}), 32'(cap));
            per_rdata = use_fixed ? fixed_rdata : 8'($urandom);
            per_ack   = 1'b1;
            log_q.push_back(per_we ? {1'b1, per_addr, per_wdata} : {1'b0, per_addr, per_rdata});
          end else begin
            wcnt--;
          end
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic idle_drive();
    rw = 1'b1; addr = RAM_BASE; wdata = 8'h00;
  endtask

  task automatic ram_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; rw = 1'b0; wdata = d;
    @(negedge clk);
    ram_model[int'(a - RAM_BASE)] = d;
    idle_drive();
  endtask

  task automatic ram_read(input string tag, input logic [15:0] a);
    addr = a; rw = 1'b1; wdata = 8'h00;
    @(negedge clk);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_rdata"}, 32'(rdata), 32'(ram_model[int'(a - RAM_BASE)]));
    idle_drive();
  endtask

  task automatic per_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; rw = 1'b0; wdata = d;
    @(negedge clk);
    idle_drive();
  endtask

  task automatic per_read(input logic [15:0] a, output int low, output int hi, output logic [7:0] got);
    addr = a; rw = 1'b1; wdata = 8'h00;
    @(negedge clk);
    idle_drive();
    low = 0; hi = 0;
    while (!ready && low < LIMIT) begin
      low++;
      if (per_req) hi++;
      @(negedge clk);
    end
    if (!ready) check("rd_ready_bound", 32'(ready), 32'd1);
    got = rdata;
    @(negedge clk);
  endtask

  // Next logged transaction must be the read of 'a' whose data the CPU received.
  task automatic check_log_rd(input string tag, input logic [15:0] a, input logic [7:0] got);
    logic [24:0] e;
    if (log_q.size() == 0) begin
      check({tag, "_logged"}, 32'(log_q.size()), 32'd1);
    end else begin
      e = log_q.pop_front();
      check({tag, "_addr"}, 32'(e[24:8]), 32'({1'b0, a}));
      check({tag, "_data"}, 32'(got), 32'(e[7:0]));
    end
  endtask

  task automatic drain_log();
    logic [24:0] e, w;
    while (log_q.size() > 0 && log_q[0][24]) begin
      e = log_q.pop_front();
      w = (exp_wr.size() > 0) ? exp_wr.pop_front() : 25'h0;
      check("rand_wr", 32'(e), 32'(w));
    end
  endtask

  function automatic logic [15:0] pick_ram();
    int r;
    r = int'($urandom_range(31, 0));
    return (r < 16) ? 16'(r) : 16'(16'h07F0 + 16'(r - 16));
  endfunction

  function automatic logic [15:0] pick_per();
    case ($urandom_range(3, 0))
      0:       return 16'h0800;
      1:       return 16'hFFFF;
      2:       return 16'h1234;
      default: return 16'(16'h8000 + 16'($urandom_range(255, 0)));
    endcase
  endfunction

  initial begin
    int          low, hi, n;
    logic [7:0]  got, d;
    logic [15:0] a;
    logic [24:0] e;

    rst = 1'b1;
    idle_drive();
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_rdata", 32'(rdata), 32'h00);
    check("rst_per_req", 32'(per_req), 32'd0);
    check("rst_per_bus", 32'({per_we, per_addr, per_wdata}), 32'd0);
    check("rst_errs", 32'({err_ovf, err_tmo}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // RAM write then read back, no peripheral activity
    ram_write(16'h0010, 8'h5A);
    ram_read("ram_rw", 16'h0010);
    check("ram_no_per_req", 32'(per_req), 32'd0);
    ram_write(16'h07FF, 8'hC3);
    ram_read("ram_top", 16'h07FF);

    // Peripheral read, ack one cycle after per_req rises
    lat_min = 1; lat_max = 1; use_fixed = 1'b1; fixed_rdata = 8'h3C;
    repeat (2) @(negedge clk);
    per_read(16'h8000, low, hi, got);
    check("prd_low_cycles", 32'(low), 32'd2);
    check("prd_req_cycles", 32'(hi), 32'd2);
    check("prd_rdata", 32'(got), 32'h3C);
    check_log_rd("prd", 16'h8000, got);
    use_fixed = 1'b0;

    // Fastest read: ack in the first per_req cycle; also first address past RAM
    lat_min = 0; lat_max = 0;
    repeat (2) @(negedge clk);
    per_read(16'h0800, low, hi, got);
    check("prd_fast_low", 32'(low), 32'd1);
    check_log_rd("prd_edge", 16'h0800, got);

    // Posted write then read: read must wait for the write's ack
    lat_min = 2; lat_max = 2;
    repeat (2) @(negedge clk);
    per_write(16'h9000, 8'h11);
    per_read(16'h9001, low, hi, got);
    check("order_log_n", 32'(log_q.size()), 32'd2);
    e = (log_q.size() > 0) ? log_q.pop_front() : 25'h0;
    check("order_wr_first", 32'(e), 32'({1'b1, 16'h9000, 8'h11}));
    check_log_rd("order_rd", 16'h9001, got);
    check("order_drained", 32'(low > 3), 32'd1);

    // Three writes with ack withheld: two queue, third overflows
    ack_en = 1'b0; lat_min = 1; lat_max = 1;
    repeat (2) @(negedge clk);
    per_write(16'hA000, 8'h01);
    per_write(16'hA001, 8'h02);
    per_write(16'hA002, 8'h03);
    err_ovf_exp = 1'b1;
    check("ovf_flag", 32'(err_ovf), 32'(err_ovf_exp));
    check("ovf_head", 32'({per_req, per_we, per_addr, per_wdata}), 32'({2'b11, 16'hA000, 8'h01}));
    repeat (5) @(negedge clk);
    check("ovf_held", 32'(log_q.size()), 32'd0);
    ack_en = 1'b1;
    n = 0;
    while (log_q.size() < 2 && n < LIMIT) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    check("ovf_emerged_n", 32'(log_q.size()), 32'd2);
    e = (log_q.size() > 0) ? log_q.pop_front() : 25'h0;
    check("ovf_wr0", 32'(e), 32'({1'b1, 16'hA000, 8'h01}));
    e = (log_q.size() > 0) ? log_q.pop_front() : 25'h0;
    check("ovf_wr1", 32'(e), 32'({1'b1, 16'hA001, 8'h02}));
    check("ovf_idle", 32'(per_req), 32'd0);

    // Read never acked: timeout after 255 cycles returns 0xFF
    ack_en = 1'b0;
    per_read(16'hC000, low, hi, got);
    err_tmo_exp = 1'b1;
    check("tmo_low", 32'(low), 32'd255);
    check("tmo_req_cycles", 32'(hi), 32'd255);
    check("tmo_rdata", 32'(got), 32'hFF);
    check("tmo_flag", 32'(err_tmo), 32'(err_tmo_exp));
    check("tmo_req_dropped", 32'(per_req), 32'd0);
    check("tmo_no_ack_log", 32'(log_q.size()), 32'd0);
    ack_en = 1'b1;

    // Randomized mix against the transaction model
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 16; i++) begin
      ram_write(16'(i), 8'($urandom));
      ram_write(16'(16'h07F0 + 16'(i)), 8'($urandom));
    end
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(3, 0))
        0: ram_write(pick_ram(), 8'($urandom));
        1: ram_read("rand_ram", pick_ram());
        2: begin
          n = 0;
          while (exp_wr.size() >= WFIFO_DEPTH && n < LIMIT) begin
            @(negedge clk); drain_log(); n++;
          end
          if (exp_wr.size() >= WFIFO_DEPTH) check("rand_wr_bound", 32'(exp_wr.size()), 32'd0);
          @(negedge clk);
          a = pick_per(); d = 8'($urandom);
          exp_wr.push_back({1'b1, a, d});
          per_write(a, d);
        end
        default: begin
          a = pick_per();
          per_read(a, low, hi, got);
          drain_log();
          check("rand_rd_order", 32'(exp_wr.size()), 32'd0);
          check_log_rd("rand_rd", a, got);
        end
      endcase
    end
    n = 0;
    while (exp_wr.size() > 0 && n < LIMIT) begin @(negedge clk); drain_log(); n++; end
    check("rand_all_wr", 32'(exp_wr.size()), 32'd0);
    check("rand_flags", 32'({err_ovf, err_tmo}), 32'({err_ovf_exp, err_tmo_exp}));

    // Asynchronous reset mid-transaction: write stuck on channel, read in DRAIN
    ack_en = 1'b0;
    repeat (3) @(negedge clk);
    log_q.delete();
    per_write(16'hB000, 8'h77);
    addr = 16'hB001; rw = 1'b1;
    @(negedge clk);
    idle_drive();
    repeat (3) @(negedge clk);
    check("mid_req_high", 32'(per_req), 32'd1);
    check("mid_ready_low", 32'(ready), 32'd0);
    #2;
    rst = 1'b1;
    err_ovf_exp = 1'b0; err_tmo_exp = 1'b0;
    #1;
    check("arst_per_req", 32'(per_req), 32'd0);
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_rdata", 32'(rdata), 32'h00);
    check("arst_per_bus", 32'({per_we, per_addr, per_wdata}), 32'd0);
    check("arst_flags", 32'({err_ovf, err_tmo}), 32'({err_ovf_exp, err_tmo_exp}));
    @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1; lat_min = 0; lat_max = 0;
    repeat (6) @(negedge clk);
    check("arst_fifo_empty", 32'({per_req, 8'(log_q.size())}), 32'd0);
    ram_read("arst_ram_kept", 16'h0010);
    per_read(16'h8000, low, hi, got);
    check("arst_recover_low", 32'(low), 32'd1);
    check_log_rd("arst_recover", 16'h8000, got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
